ahb2apb_apb_sequencer: RTL
==========================

# ahb2apb_apb_sequencer

APB-domain transfer sequencer of the AHB-to-APB bridge. Pops transfer commands from the command async FIFO's read side, runs each as one APB SETUP/ACCESS transfer, and pushes a response word into the response async FIFO's write side. Includes a PREADY timeout so a hung slave cannot stall the bridge.

## Interface
- AW, 32: APB address width
- DW, 32: APB data width; SW = DW/8 strobe bits
- TIMEOUT, 255: max ACCESS cycles without PREADY; 0 disables timeout
- clk  in  1  APB clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_rempty_i  in  1  command FIFO empty
- cmd_rdata_i  in  CW  command word at FIFO head, CW = 1+3+SW+AW+DW
- cmd_rfifo_o  out  1  command FIFO read request; one pop per cycle asserted
- rsp_wfull_i  in  1  response FIFO full
- rsp_wfifo_o  out  1  response FIFO write request
- rsp_wdata_o  out  DW+1  response word {slverr, rdata}
- psel_o, penable_o, pwrite_o  out  1  APB controls
- paddr_o  out  AW; pwdata_o  out  DW; pstrb_o  out  SW; pprot_o  out  3
- pready_i, pslverr_i  in  1; prdata_i  in  DW
- busy_o  out  1  state != IDLE
- timeout_o  out  1  one-cycle pulse on timeout completion

## Operation
- Command word MSB->LSB: {write, prot[2:0], strb[SW-1:0], addr[AW-1:0], wdata[DW-1:0]}.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: if !cmd_rempty_i, assert cmd_rfifo_o, latch all command fields into APB output registers, -> SETUP. Else stay.
- SETUP: psel=1, penable=0 -> ACCESS unconditionally.
- ACCESS: psel=1, penable=1. Completion when pready_i=1, or timeout (TIMEOUT!=0 and ACCESS cycle count reaches TIMEOUT with pready_i=0).
- On completion: response = {pslverr_i, write ? 0 : prdata_i}; on timeout {1, 0} and timeout_o=1. If !rsp_wfull_i push same cycle, -> IDLE; else hold response in register, -> RESP.
- RESP: psel=penable=0; assert rsp_wfifo_o when !rsp_wfull_i, then -> IDLE.
- Every command yields exactly one response (writes included); order preserved.
- pstrb_o forced 0 on reads; pwdata_o holds last value on reads.
- APB address/data/control outputs stable from SETUP through completion.

## Timing
- Reset: state IDLE; all outputs 0 (psel, penable, pwrite, paddr, pwdata, pstrb, pprot, cmd_rfifo_o, rsp_wfifo_o, rsp_wdata_o, busy_o, timeout_o).
- cmd_rfifo_o and rsp_wfifo_o are combinational from state and FIFO flags; never asserted when the matching empty/full flag is high.
- Pop at cycle N -> SETUP N+1 -> ACCESS N+2 -> earliest push N+2 (zero-wait slave) -> next pop N+3. Minimum 3 cycles per transfer.
- Wait states: each pready_i=0 cycle in ACCESS adds one cycle; counter starts at 1 on first ACCESS cycle, clears on leaving ACCESS.
- Timeout: with TIMEOUT=T, completion in ACCESS cycle T if pready_i never high; pready_i=1 in cycle T is normal completion (no timeout).
- Reset mid-transfer: outputs drop to 0 immediately; the popped command and pending response are discarded.

## Structure
- Package ahb2apb_pkg: command field offsets/widths (CW, field LSB constants), response width, state enum type.
- Sub-module ahb2apb_apb_timeout: counter of width $clog2(TIMEOUT+1), inputs start/active, output expired; tied off when TIMEOUT=0.

## Test plan
- Single write addr 0x1000, wdata 0xA5A5_0001, strb 0xF, pready=1: pop N, psel N+1, penable N+2, response {0, 0} pushed N+2.
- Read addr 0x2004, prdata 0xDEAD_BEEF, 3 wait states: ACCESS lasts 4 cycles, response {0, 0xDEADBEEF}, strb 0.
- pslverr_i=1 on write: response {1, 0}; next queued command popped following cycle.
- TIMEOUT=4, pready held 0: completion in ACCESS cycle 4, timeout_o pulse, response {1, 0}, psel drops next cycle.
- rsp_wfull_i=1 at completion for 5 cycles: RESP holds, no pop, push on first cycle full deasserts, then IDLE.
- Reset asserted during ACCESS: all outputs 0 same edge; after release, next command starts clean from IDLE.

Source files
------------

// File: rtl/ahb2apb_pkg.sv
// ahb2apb_pkg: command/response word layout and sequencer state type shared by the APB side of the bridge.
package ahb2apb_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} apb_state_e;

    // Command word, MSB->LSB: {write, prot[2:0], strb[SW-1:0], addr[AW-1:0], wdata[DW-1:0]}
    function automatic int cmd_width(input int aw, input int dw);
        return 4 + dw / 8 + aw + dw;
    endfunction

    function automatic int addr_lsb(input int dw);
        return dw;
    endfunction

    function automatic int strb_lsb(input int aw, input int dw);
        return aw + dw;
    endfunction

    function automatic int prot_lsb(input int aw, input int dw);
        return aw + dw + dw / 8;
    endfunction

    function automatic int write_bit(input int aw, input int dw);
        return aw + dw + dw / 8 + 3;
    endfunction

    // Response word: {slverr, rdata}
    function automatic int rsp_width(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/ahb2apb_apb_timeout.sv
// ahb2apb_apb_timeout: counts ACCESS cycles and flags the cycle in which the PREADY limit is reached.
module ahb2apb_apb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic active,
    output logic expired
);

    if (TIMEOUT == 0) begin : g_off
        logic unused;
        assign unused = ^{clk, rst_n, start, active};
        assign expired = 1'b0;
    end else begin : g_on
        localparam int CNTW = $clog2(TIMEOUT + 1);
        localparam logic [CNTW-1:0] LIMIT = CNTW'(TIMEOUT);
        logic [CNTW-1:0] cnt;
        // Loaded with 1 so the count equals the ACCESS cycle number.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt <= '0;
            else cnt <= start ? CNTW'(1) : active ? cnt + CNTW'(1) : '0;
        end
        assign expired = active && cnt == LIMIT;
    end

endmodule

// File: rtl/ahb2apb_apb_sequencer.sv
// ahb2apb_apb_sequencer: pops one bridge command, runs one APB SETUP/ACCESS transfer,
// and pushes exactly one {slverr, rdata} response per command, with a PREADY timeout.
module ahb2apb_apb_sequencer
    import ahb2apb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int TIMEOUT = 255,
    localparam int SW = DW / 8,
    localparam int CW = cmd_width(AW, DW),
    localparam int RW = rsp_width(DW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_rempty_i,
    input  logic [CW-1:0] cmd_rdata_i,
    output logic          cmd_rfifo_o,
    input  logic          rsp_wfull_i,
    output logic          rsp_wfifo_o,
    output logic [RW-1:0] rsp_wdata_o,
    output logic          psel_o,
    output logic          penable_o,
    output logic          pwrite_o,
    output logic [AW-1:0] paddr_o,
    output logic [DW-1:0] pwdata_o,
    output logic [SW-1:0] pstrb_o,
    output logic [2:0]    pprot_o,
    input  logic          pready_i,
    input  logic          pslverr_i,
    input  logic [DW-1:0] prdata_i,
    output logic          busy_o,
    output logic          timeout_o
);

    localparam int ADDR_LSB = addr_lsb(DW);
    localparam int STRB_LSB = strb_lsb(AW, DW);
    localparam int PROT_LSB = prot_lsb(AW, DW);
    localparam int WR_BIT   = write_bit(AW, DW);

    apb_state_e state, next;
    logic [RW-1:0] rsp_q, rsp_d;
    logic expired, done;

    ahb2apb_apb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (state == ST_SETUP),
        .active  (state == ST_ACCESS),
        .expired (expired)
    );

    assign psel_o      = state == ST_SETUP || state == ST_ACCESS;
    assign penable_o   = state == ST_ACCESS;
    assign busy_o      = state != ST_IDLE;
    assign rsp_wdata_o = (state == ST_RESP || done) ? rsp_d : '0;

    always_comb begin
        next        = state;
        cmd_rfifo_o = 1'b0;
        rsp_wfifo_o = 1'b0;
        timeout_o   = 1'b0;
        done        = 1'b0;
        rsp_d       = rsp_q;
        case (state)
            ST_IDLE: begin
                cmd_rfifo_o = !cmd_rempty_i;
                next        = cmd_rempty_i ? ST_IDLE : ST_SETUP;
            end
            ST_SETUP: next = ST_ACCESS;
            ST_ACCESS: if (pready_i || expired) begin
                // A ready slave in the limit cycle wins over the timeout.
                done        = 1'b1;
                timeout_o   = !pready_i;
                rsp_d       = !pready_i ? {1'b1, {DW{1'b0}}} : {pslverr_i, pwrite_o ? {DW{1'b0}} : prdata_i};
                rsp_wfifo_o = !rsp_wfull_i;
                next        = rsp_wfull_i ? ST_RESP : ST_IDLE;
            end
            ST_RESP: begin
                rsp_wfifo_o = !rsp_wfull_i;
                next        = rsp_wfull_i ? ST_RESP : ST_IDLE;
            end
            default: next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rsp_q    <= '0;
            pwrite_o <= 1'b0;
            paddr_o  <= '0;
            pwdata_o <= '0;
            pstrb_o  <= '0;
            pprot_o  <= '0;
        end else begin
            state <= next;
            rsp_q <= rsp_d;
            if (cmd_rfifo_o) begin
                pwrite_o <= cmd_rdata_i[WR_BIT];
                pprot_o  <= cmd_rdata_i[PROT_LSB +: 3];
                paddr_o  <= cmd_rdata_i[ADDR_LSB +: AW];
                pstrb_o  <= cmd_rdata_i[WR_BIT] ? cmd_rdata_i[STRB_LSB +: SW] : '0;
                if (cmd_rdata_i[WR_BIT]) pwdata_o <= cmd_rdata_i[DW-1:0];
            end
        end
    end

endmodule
